// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the
// instruction-fetch side (i_*) and the load/store side (d_*).
//   clk, rst_n             : clock, synchronous active-low reset
//   i_req/i_addr           : fetch request, held until i_ack
//   i_rdata/i_ack          : fetched word and one-cycle acknowledge
//   d_req/d_we/d_byte      : data request, store select, byte access
//   d_addr/d_wdata         : data address and store data
//   d_rdata/d_ack          : load data and one-cycle acknowledge
//   mem_req/mem_we/mem_byte: memory access active, write strobe, byte access
//   mem_addr/mem_wdata     : latched address and store data
//   mem_rdata              : read data, valid on the final access cycle
// Build option MEM_ARB_RR_EN: round-robin on a tie; otherwise the data side
// always wins a tie.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_byte,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mreq_q, mreq_d;
  logic          we_q, we_d;
  logic          byte_q, byte_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   irdata_q, irdata_d;
  logic [31:0]   drdata_q, drdata_d;
  logic          iack_q, iack_d;
  logic          dack_q, dack_d;
  logic          pick_d;  // 1 = data side wins this grant
`ifdef MEM_ARB_RR_EN
  logic          last_q, last_d;  // 1 = data side won the last grant
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mreq_d   = 1'b0;
    we_d     = we_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    pick_d   = d_req;
`ifdef MEM_ARB_RR_EN
    last_d   = last_q;
    if (i_req && d_req) pick_d = ~last_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = pick_d ? BUSY_D : BUSY_I;
          cnt_d   = CW'(LATENCY - 1);
          mreq_d  = 1'b1;
          addr_d  = pick_d ? d_addr : i_addr;
          wdata_d = pick_d ? d_wdata : '0;
          we_d    = pick_d & d_we;
          byte_d  = pick_d & d_byte;
`ifdef MEM_ARB_RR_EN
          last_d  = pick_d;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          // we/byte are cleared on exit so the registered strobes drop with mem_req
          we_d    = 1'b0;
          byte_d  = 1'b0;
          if (state_q == BUSY_I) begin
            irdata_d = mem_rdata;
            iack_d   = 1'b1;
          end else begin
            dack_d = 1'b1;
            if (!we_q) drdata_d = byte_q ? {24'b0, mem_rdata[7:0]} : mem_rdata;
          end
        end else begin
          cnt_d  = cnt_q - CW'(1);
          mreq_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mreq_q   <= 1'b0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mreq_q   <= mreq_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
`ifdef MEM_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign mem_req   = mreq_q;
  assign mem_we    = we_q;
  assign mem_byte  = byte_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = irdata_q;
  assign i_ack     = iack_q;
  assign d_rdata   = drdata_q;
  assign d_ack     = dack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned L = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, d_byte;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_ack, d_ack, mem_req, mem_we, mem_byte;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: a grant at edge g owns the port for edges
  // g..g+L+1; mem_req during cycles after edges g..g+L-1, ack after g+L.
  int          m_k = 0;      // edge index
  int          m_g = 0;      // edge of the current grant
  bit          m_gvalid = 0;
  int          m_free = 0;   // first edge at which a new grant may happen
  bit          m_side;       // 1 = data
  bit          m_last = 1;
  bit          m_we, m_byte;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;

  task automatic step();
    logic        s_rst, s_ireq, s_dreq, s_dwe, s_dbyte, pick, busy, ack, rstc;
    logic [31:0] s_iaddr, s_daddr, s_dwdata, s_mrd;
    s_rst = rst_n; s_ireq = i_req; s_dreq = d_req; s_dwe = d_we; s_dbyte = d_byte;
    s_iaddr = i_addr; s_daddr = d_addr; s_dwdata = d_wdata; s_mrd = mem_rdata;
    @(posedge clk);
    #1;
    m_k++;
    rstc = !s_rst;
    if (rstc) begin
      m_gvalid = 0; m_free = m_k + 1; m_last = 1;
      m_irdata = '0; m_drdata = '0; m_addr = '0; m_wdata = '0;
      m_we = 0; m_byte = 0; m_side = 0;
    end else begin
      if (m_gvalid && m_k == m_g + int'(L)) begin
        if (!m_side) m_irdata = s_mrd;
        else if (!m_we) m_drdata = m_byte ? {24'h0, s_mrd[7:0]} : s_mrd;
      end
      if (m_k >= m_free && (s_ireq || s_dreq)) begin
`ifdef MEM_ARB_RR_EN
        pick = (s_ireq && s_dreq) ? !m_last : s_dreq;
`else
        pick = s_dreq;
`endif
        m_last = pick; m_side = pick; m_g = m_k; m_gvalid = 1;
        m_free = m_k + int'(L) + 2;
        m_addr  = pick ? s_daddr : s_iaddr;
        m_wdata = s_dwdata;
        m_we    = pick && s_dwe;
        m_byte  = pick && s_dbyte;
      end
    end
    busy = m_gvalid && (m_k - m_g) < int'(L);
    ack  = m_gvalid && (m_k - m_g) == int'(L);
    check("mem_req", mem_req, busy);
    check("i_ack", i_ack, ack && !m_side);
    check("d_ack", d_ack, ack && m_side);
    check("i_rdata", i_rdata, m_irdata);
    check("d_rdata", d_rdata, m_drdata);
    check("mem_we", mem_we, busy && m_we);
    if (busy || rstc) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_byte", mem_byte, m_byte);
    end
    if (rstc) check("mem_wdata_rst", mem_wdata, 32'h0);
    else if (busy && m_we) check("mem_wdata", mem_wdata, m_wdata);
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    int          ord[$];
    int          exp_ord[4];
    bit          seen;
    rst_n = 0; i_req = 0; d_req = 0; d_we = 0; d_byte = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    idle_cycles(3);
    rst_n = 1;
    idle_cycles(2);

    // single fetch
    i_req = 1; i_addr = 32'h100; mem_rdata = 32'h00500093;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (i_ack) begin
        seen = 1; i_req = 0;
        check("fetch_rdata", i_rdata, 32'h00500093);
        check("fetch_latency", c, L);
      end
    end
    if (!seen) check("fetch_ack_seen", 0, 1);
    idle_cycles(2);

    // byte load
    d_req = 1; d_we = 0; d_byte = 1; d_addr = 32'h203; mem_rdata = 32'hAABBCC8F;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (d_ack) begin
        seen = 1; d_req = 0;
        check("byte_load_rdata", d_rdata, 32'h0000008F);
      end
    end
    if (!seen) check("byte_ack_seen", 0, 1);
    idle_cycles(2);

    // store: d_rdata must hold the previous load value
    d_req = 1; d_we = 1; d_byte = 0; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    mem_rdata = 32'h12345678;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (d_ack) begin
        seen = 1; d_req = 0; d_we = 0;
        check("store_rdata_hold", d_rdata, 32'h0000008F);
      end
    end
    if (!seen) check("store_ack_seen", 0, 1);
    idle_cycles(2);

    // tie with both requests held continuously, pointer freshly reset
    rst_n = 0; step(); rst_n = 1;
    i_req = 1; i_addr = 32'h500; d_req = 1; d_addr = 32'h600; d_byte = 0;
`ifdef MEM_ARB_RR_EN
    exp_ord = '{0, 1, 0, 1};
`else
    exp_ord = '{1, 1, 1, 1};
`endif
    for (int c = 0; c < 4 * (int'(L) + 2) + 2; c++) begin
      mem_rdata = $urandom;
      step();
      if (d_ack) ord.push_back(1);
      if (i_ack) ord.push_back(0);
    end
    check("tie_grants", ord.size(), 4);
    for (int n = 0; n < 4; n++)
      if (n < ord.size()) check("tie_order", ord[n], exp_ord[n]);
    i_req = 0; d_req = 0;
    idle_cycles(int'(L) + 3);

    // reset during the second BUSY cycle of a fetch, then re-issue
    i_req = 1; i_addr = 32'h300; mem_rdata = 32'hCAFEF00D;
    step(); step();
    rst_n = 0; step(); rst_n = 1;
    check("abort_mem_req", mem_req, 0);
    check("abort_i_ack", i_ack, 0);
    seen = 0;
    for (int c = 0; c < int'(L) + 4 && !seen; c++) begin
      step();
      if (i_ack) begin
        seen = 1; i_req = 0;
        check("reissue_rdata", i_rdata, 32'hCAFEF00D);
      end
    end
    if (!seen) check("reissue_ack_seen", 0, 1);
    idle_cycles(2);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      mem_rdata = $urandom;
      step();
      if (i_req) begin
        if (i_ack) begin
          if ($urandom_range(0, 3) == 0) i_addr = $urandom;
          else i_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (d_req) begin
        if (d_ack) begin
          if ($urandom_range(0, 3) == 0) begin
            d_we = $urandom; d_byte = $urandom; d_addr = $urandom; d_wdata = $urandom;
          end else d_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = $urandom; d_byte = $urandom; d_addr = $urandom; d_wdata = $urandom;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
